pipeline_ctrl: RTL and testbench

//   Central stall/flush/forwarding sequencer for the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/core_defs.sv | 38 +++
 rtl/hazard_detect.sv | 61 ++++++
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_defs.sv
// ---------------------------------------------------------------------------
// core_defs: shared encodings for the pipeline controller.
//   fwd_sel_e    : ALU operand source (register file, MEM result, WB result)
//   trap_cause_e : trap cause reported alongside trap_o
//   ctrl_state_e : pipeline_ctrl sequencer states
//   STALL_* / FLUSH_* : common stall {MEM,EX,ID,IF} and flush {MEM,EX,ID} patterns
// ---------------------------------------------------------------------------
package core_defs;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'b00,
    TRAP_ILLEGAL  = 2'b01,
    TRAP_DMEM_TMO = 2'b10
  } trap_cause_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DMEM_WAIT,
    ST_FENCE_DRAIN,
    ST_TRAP_FLUSH
  } ctrl_state_e;

  localparam logic [3:0] STALL_NONE  = 4'b0000;
  localparam logic [3:0] STALL_FRONT = 4'b0011;
  localparam logic [3:0] STALL_ALL   = 4'b1111;

  localparam logic [2:0] FLUSH_NONE  = 3'b000;
  localparam logic [2:0] FLUSH_EX    = 3'b010;
  localparam logic [2:0] FLUSH_ID_EX = 3'b011;
  localparam logic [2:0] FLUSH_ALL   = 3'b111;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect: combinational compare of the ID source registers against the
// EX/MEM/WB destinations.
//   Inputs : id_rs1/id_rs2, and per stage valid, reg write-enable and rd.
//   Outputs: raw_ex/raw_mem/raw_wb - ID reads a register that stage will write
//            fwd_a/fwd_b           - operand source for rs1/rs2 (MEM beats WB)
// A producer only counts when it is valid, writes rd, and rd is not x0.
// Build option: PIPE_CTRL_FWD_EN enables forward selects; otherwise both are
// tied to the register file.
// ---------------------------------------------------------------------------
module hazard_detect
  import core_defs::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              raw_ex,
  output logic              raw_mem,
  output logic              raw_wb,
  output fwd_sel_e          fwd_a,
  output fwd_sel_e          fwd_b
);

  logic ex_live, mem_live, wb_live;
  logic mem_a, mem_b, wb_a, wb_b;

  assign ex_live  = ex_valid  && ex_we  && (ex_rd  != '0);
  assign mem_live = mem_valid && mem_we && (mem_rd != '0);
  assign wb_live  = wb_valid  && wb_we  && (wb_rd  != '0);

  assign mem_a = mem_live && (mem_rd == id_rs1);
  assign mem_b = mem_live && (mem_rd == id_rs2);
  assign wb_a  = wb_live  && (wb_rd  == id_rs1);
  assign wb_b  = wb_live  && (wb_rd  == id_rs2);

  assign raw_ex  = ex_live && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign raw_mem = mem_a || mem_b;
  assign raw_wb  = wb_a  || wb_b;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
`ifdef PIPE_CTRL_FWD_EN
    if (mem_a)     fwd_a = FWD_MEM;
    else if (wb_a) fwd_a = FWD_WB;
    if (mem_b)     fwd_b = FWD_MEM;
    else if (wb_b) fwd_b = FWD_WB;
`endif
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl: stall/flush/forwarding sequencer for the IF/ID/EX/MEM/WB core.
// Ports:
//   clk_i, rst_i (async, active-high)
//   id_*   : ID valid, rs1/rs2, FENCE and illegal-instruction flags
//   ex_*   : EX valid, rd, reg write, load flag, resolved redirect
//   mem_*  : MEM valid, rd, reg write; dmem_req_i/dmem_ack_i handshake
//   wb_*   : WB valid, rd, reg write
//   stall_o {MEM,EX,ID,IF}, flush_o {MEM,EX,ID}, fwd_a_o/fwd_b_o operand
//   selects, trap_o one-cycle trap pulse with trap_cause_o.
// Parameters: REG_AW, DMEM_TMO (dmem watchdog limit, 1..255),
//   TRAP_FLUSH_N (flush-all cycles after a trap, 1..3).
// Build option: PIPE_CTRL_FWD_EN - MEM/WB RAW hazards are forwarded and only
//   load-use stalls; without it any RAW against EX/MEM/WB stalls.
// All outputs are combinational and forced low while rst_i is high.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import core_defs::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DMEM_TMO     = 255,
  parameter int unsigned TRAP_FLUSH_N = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_is_fence_i,
  input  logic              id_illegal_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_we_i,
  input  logic              ex_is_ld_i,
  input  logic              ex_redirect_i,
  input  logic              mem_valid_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_we_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_we_i,
  output logic [3:0]        stall_o,
  output logic [2:0]        flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o
);

  localparam logic [7:0] WD_LIMIT = 8'(DMEM_TMO);
  localparam logic [1:0] TF_LAST  = 2'(TRAP_FLUSH_N - 1);

  ctrl_state_e state_q, state_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic [1:0]  tf_cnt_q, tf_cnt_d;

  logic        raw_ex, raw_mem, raw_wb;
  fwd_sel_e    hd_fwd_a, hd_fwd_b;
  logic        data_hazard, fence_block;

  logic [3:0]  stall_d;
  logic [2:0]  flush_d;
  logic        trap_d;
  trap_cause_e cause_d;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_rs1    (id_rs1_i),
    .id_rs2    (id_rs2_i),
    .ex_valid  (ex_valid_i),
    .ex_we     (ex_reg_we_i),
    .ex_rd     (ex_rd_i),
    .mem_valid (mem_valid_i),
    .mem_we    (mem_reg_we_i),
    .mem_rd    (mem_rd_i),
    .wb_valid  (wb_valid_i),
    .wb_we     (wb_reg_we_i),
    .wb_rd     (wb_rd_i),
    .raw_ex    (raw_ex),
    .raw_mem   (raw_mem),
    .raw_wb    (raw_wb),
    .fwd_a     (hd_fwd_a),
    .fwd_b     (hd_fwd_b)
  );

`ifdef PIPE_CTRL_FWD_EN
  // MEM/WB producers are covered by the forward muxes; only a load still in
  // EX cannot be forwarded in time.
  logic unused_raw;
  assign unused_raw  = raw_mem | raw_wb;
  assign data_hazard = id_valid_i && raw_ex && ex_is_ld_i;
`else
  // Without forwarding a load in EX is just another RAW producer.
  logic unused_ld;
  assign unused_ld   = ex_is_ld_i;
  assign data_hazard = id_valid_i && (raw_ex || raw_mem || raw_wb);
`endif

  assign fence_block = id_valid_i && id_is_fence_i &&
                       (ex_valid_i || mem_valid_i || wb_valid_i);

  // DMEM_WAIT on its ack cycle and FENCE_DRAIN both fall through to the RUN
  // priority chain: the pipe moves that cycle, so a fence that is still
  // blocked re-enters FENCE_DRAIN and a pending illegal is taken then.
  always_comb begin
    state_d  = ST_RUN;
    wd_cnt_d = '0;
    tf_cnt_d = '0;
    stall_d  = STALL_NONE;
    flush_d  = FLUSH_NONE;
    trap_d   = 1'b0;
    cause_d  = TRAP_NONE;

    if (state_q == ST_TRAP_FLUSH) begin
      flush_d = FLUSH_ALL;
      if (tf_cnt_q != TF_LAST) begin
        state_d  = ST_TRAP_FLUSH;
        tf_cnt_d = tf_cnt_q + 2'd1;
      end
    end else if ((state_q == ST_DMEM_WAIT) && !dmem_ack_i) begin
      if (wd_cnt_q == WD_LIMIT) begin
        trap_d  = 1'b1;
        cause_d = TRAP_DMEM_TMO;
        state_d = ST_TRAP_FLUSH;
      end else begin
        stall_d  = STALL_ALL;
        wd_cnt_d = wd_cnt_q + 8'd1;
        state_d  = ST_DMEM_WAIT;
      end
    end else if (dmem_req_i && !dmem_ack_i) begin
      stall_d  = STALL_ALL;
      wd_cnt_d = 8'd1;
      state_d  = ST_DMEM_WAIT;
    end else if (id_valid_i && id_illegal_i && !ex_redirect_i) begin
      trap_d  = 1'b1;
      cause_d = TRAP_ILLEGAL;
      state_d = ST_TRAP_FLUSH;
    end else if (ex_redirect_i) begin
      flush_d = FLUSH_ID_EX;
    end else if (data_hazard) begin
      stall_d = STALL_FRONT;
      flush_d = FLUSH_EX;
    end else if (fence_block) begin
      stall_d = STALL_FRONT;
      flush_d = FLUSH_EX;
      state_d = ST_FENCE_DRAIN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      wd_cnt_q <= '0;
      tf_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      tf_cnt_q <= tf_cnt_d;
    end
  end

  assign stall_o      = rst_i ? STALL_NONE : stall_d;
  assign flush_o      = rst_i ? FLUSH_NONE : flush_d;
  assign fwd_a_o      = rst_i ? FWD_RF     : hd_fwd_a;
  assign fwd_b_o      = rst_i ? FWD_RF     : hd_fwd_b;
  assign trap_o       = rst_i ? 1'b0       : trap_d;
  assign trap_cause_o = rst_i ? TRAP_NONE  : cause_d;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned TB_TMO = 4;
  localparam int unsigned TB_TFN = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i, id_is_fence_i, id_illegal_i;
  logic [4:0] id_rs1_i, id_rs2_i;
  logic       ex_valid_i, ex_reg_we_i, ex_is_ld_i, ex_redirect_i;
  logic [4:0] ex_rd_i;
  logic       mem_valid_i, mem_reg_we_i, dmem_req_i, dmem_ack_i;
  logic [4:0] mem_rd_i;
  logic       wb_valid_i, wb_reg_we_i;
  logic [4:0] wb_rd_i;
  logic [3:0] stall_o;
  logic [2:0] flush_o;
  logic [1:0] fwd_a_o, fwd_b_o, trap_cause_o;
  logic       trap_o;

  typedef struct packed {
    logic [3:0] stall;
    logic [2:0] flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       trap;
    logic [1:0] cause;
  } exp_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model: cycles spent waiting on dmem, flush-all cycles left
  int unsigned m_wait = 0;
  int unsigned m_flush_left = 0;

  logic [3:0] obs_stall;
  logic [2:0] obs_flush;
  logic [1:0] obs_fa, obs_cause;
  logic       obs_trap;

  pipeline_ctrl #(
    .REG_AW       (5),
    .DMEM_TMO     (TB_TMO),
    .TRAP_FLUSH_N (TB_TFN)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_is_fence_i (id_is_fence_i),
    .id_illegal_i  (id_illegal_i),
    .ex_valid_i    (ex_valid_i),
    .ex_rd_i       (ex_rd_i),
    .ex_reg_we_i   (ex_reg_we_i),
    .ex_is_ld_i    (ex_is_ld_i),
    .ex_redirect_i (ex_redirect_i),
    .mem_valid_i   (mem_valid_i),
    .mem_rd_i      (mem_rd_i),
    .mem_reg_we_i  (mem_reg_we_i),
    .dmem_req_i    (dmem_req_i),
    .dmem_ack_i    (dmem_ack_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .wb_reg_we_i   (wb_reg_we_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .trap_o        (trap_o),
    .trap_cause_o  (trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return v && we && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
`ifdef PIPE_CTRL_FWD_EN
    if (writes(mem_valid_i, mem_reg_we_i, mem_rd_i, rs)) return 2'b01;
    if (writes(wb_valid_i, wb_reg_we_i, wb_rd_i, rs))    return 2'b10;
`endif
    return (rs === 5'bx) ? 2'b11 : 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit   hit_ex, hit_mem, hit_wb, need_stall, busy;
    e       = '0;
    hit_ex  = writes(ex_valid_i, ex_reg_we_i, ex_rd_i, id_rs1_i)   || writes(ex_valid_i, ex_reg_we_i, ex_rd_i, id_rs2_i);
    hit_mem = writes(mem_valid_i, mem_reg_we_i, mem_rd_i, id_rs1_i) || writes(mem_valid_i, mem_reg_we_i, mem_rd_i, id_rs2_i);
    hit_wb  = writes(wb_valid_i, wb_reg_we_i, wb_rd_i, id_rs1_i)   || writes(wb_valid_i, wb_reg_we_i, wb_rd_i, id_rs2_i);
    busy    = ex_valid_i || mem_valid_i || wb_valid_i;
`ifdef PIPE_CTRL_FWD_EN
    need_stall = hit_ex && ex_is_ld_i;
`else
    need_stall = hit_ex || hit_mem || hit_wb;
`endif
    e.fa = fwd_of(id_rs1_i);
    e.fb = fwd_of(id_rs2_i);
    if (m_flush_left > 0) begin
      e.flush = 3'b111;
    end else if (m_wait > 0 && !dmem_ack_i) begin
      if (m_wait >= TB_TMO) begin
        e.trap  = 1'b1;
        e.cause = 2'b10;
      end else begin
        e.stall = 4'b1111;
      end
    end else if (dmem_req_i && !dmem_ack_i) begin
      e.stall = 4'b1111;
    end else if (id_valid_i && id_illegal_i && !ex_redirect_i) begin
      e.trap  = 1'b1;
      e.cause = 2'b01;
    end else if (ex_redirect_i) begin
      e.flush = 3'b011;
    end else if (id_valid_i && (need_stall || (id_is_fence_i && busy))) begin
      e.stall = 4'b0011;
      e.flush = 3'b010;
    end
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    if (m_flush_left > 0) m_flush_left--;
    else if (e.trap)      m_flush_left = TB_TFN;
    m_wait = (e.stall == 4'b1111) ? m_wait + 1 : 0;
  endtask

  // inputs are set after a rising edge; outputs are compared on the falling edge
  task automatic run_cycle();
    exp_t e;
    @(negedge clk_i);
    e = model();
    obs_stall = stall_o;
    obs_flush = flush_o;
    obs_fa    = fwd_a_o;
    obs_trap  = trap_o;
    obs_cause = trap_cause_o;
    check_eq("stall", 8'(stall_o), 8'(e.stall));
    check_eq("flush", 8'(flush_o), 8'(e.flush));
    check_eq("fwd_a", 8'(fwd_a_o), 8'(e.fa));
    check_eq("fwd_b", 8'(fwd_b_o), 8'(e.fb));
    check_eq("trap", 8'(trap_o), 8'(e.trap));
    check_eq("cause", 8'(trap_cause_o), 8'(e.cause));
    model_step(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_is_fence_i = 0; id_illegal_i = 0;
    ex_valid_i = 0; ex_rd_i = 0; ex_reg_we_i = 0; ex_is_ld_i = 0; ex_redirect_i = 0;
    mem_valid_i = 0; mem_rd_i = 0; mem_reg_we_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; wb_reg_we_i = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 8'(stall_o), 8'h00);
    check_eq({tag, "_flush"}, 8'(flush_o), 8'h00);
    check_eq({tag, "_fwd"}, 8'({fwd_a_o, fwd_b_o}), 8'h00);
    check_eq({tag, "_trap"}, 8'({trap_o, trap_cause_o}), 8'h00);
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    // producer in MEM matching rs1 so a forward select would show if not held off
    id_valid_i = 1; id_rs1_i = 5'd3; mem_valid_i = 1; mem_rd_i = 5'd3; mem_reg_we_i = 1;
    dmem_req_i = 1;
    #12;
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_inputs();
    run_cycle();

    // load-use: EX lw x5, ID add x6,x5,x1
    id_valid_i = 1; id_rs1_i = 5'd5; id_rs2_i = 5'd1;
    ex_valid_i = 1; ex_rd_i = 5'd5; ex_reg_we_i = 1; ex_is_ld_i = 1;
    run_cycle();
    check_eq("lu_stall", 8'(obs_stall), 8'h03);
    check_eq("lu_flush", 8'(obs_flush), 8'h02);
    ex_valid_i = 0; ex_is_ld_i = 0; ex_reg_we_i = 0;
    mem_valid_i = 1; mem_rd_i = 5'd5; mem_reg_we_i = 1;
    run_cycle();
`ifdef PIPE_CTRL_FWD_EN
    check_eq("lu_fwd_a", 8'(obs_fa), 8'h01);
    check_eq("lu_after_stall", 8'(obs_stall), 8'h00);
`else
    check_eq("lu_fwd_a", 8'(obs_fa), 8'h00);
    check_eq("lu_after_stall", 8'(obs_stall), 8'h03);
`endif

    // dmem wait, ack on the fourth cycle
    clear_inputs();
    dmem_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check_eq("dw_stall", 8'(obs_stall), 8'h0f);
    end
    dmem_ack_i = 1;
    run_cycle();
    check_eq("dw_ack_stall", 8'(obs_stall), 8'h00);
    clear_inputs();
    run_cycle();

    // dmem watchdog: no ack
    dmem_req_i = 1;
    for (int i = 0; i < int'(TB_TMO); i++) begin
      run_cycle();
      check_eq("tmo_stall", 8'(obs_stall), 8'h0f);
    end
    run_cycle();
    check_eq("tmo_trap", 8'(obs_trap), 8'h01);
    check_eq("tmo_cause", 8'(obs_cause), 8'h02);
    dmem_req_i = 0;
    id_valid_i = 1; id_illegal_i = 1;   // must be ignored while flushing
    for (int i = 0; i < int'(TB_TFN); i++) begin
      run_cycle();
      check_eq("tf_flush", 8'(obs_flush), 8'h07);
      check_eq("tf_no_trap", 8'(obs_trap), 8'h00);
    end
    clear_inputs();
    run_cycle();
    check_eq("tf_done", 8'(obs_flush), 8'h00);

    // fence drains three busy stages
    id_valid_i = 1; id_is_fence_i = 1;
    ex_valid_i = 1; mem_valid_i = 1; wb_valid_i = 1;
    run_cycle();
    check_eq("fence_s0", 8'(obs_stall), 8'h03);
    ex_valid_i = 0;
    run_cycle();
    check_eq("fence_s1", 8'(obs_stall), 8'h03);
    mem_valid_i = 0;
    run_cycle();
    check_eq("fence_s2", 8'(obs_stall), 8'h03);
    wb_valid_i = 0;
    run_cycle();
    check_eq("fence_go", 8'({obs_stall, obs_flush}), 8'h00);

    // illegal vs redirect, then illegal alone
    clear_inputs();
    id_valid_i = 1; id_illegal_i = 1; ex_redirect_i = 1;
    run_cycle();
    check_eq("ill_redir_flush", 8'(obs_flush), 8'h03);
    check_eq("ill_redir_trap", 8'(obs_trap), 8'h00);
    ex_redirect_i = 0;
    run_cycle();
    check_eq("ill_trap", 8'({obs_trap, obs_cause}), 8'h05);
    clear_inputs();
    repeat (3) run_cycle();

    // async reset in the middle of a dmem wait
    dmem_req_i = 1;
    repeat (2) run_cycle();
    rst_i = 1'b1;
    #2;
    check_all_zero("rst_wait");
    m_wait = 0;
    m_flush_left = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_inputs();
    run_cycle();
    check_eq("rst_run", 8'(obs_stall), 8'h00);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      id_valid_i    = ($urandom_range(0, 9) < 8);
      id_rs1_i      = 5'($urandom_range(0, 3));
      id_rs2_i      = 5'($urandom_range(0, 3));
      id_is_fence_i = ($urandom_range(0, 9) == 0);
      id_illegal_i  = ($urandom_range(0, 19) == 0);
      ex_valid_i    = ($urandom_range(0, 9) < 6);
      ex_rd_i       = 5'($urandom_range(0, 3));
      ex_reg_we_i   = ($urandom_range(0, 9) < 7);
      ex_is_ld_i    = ($urandom_range(0, 9) < 3);
      ex_redirect_i = ($urandom_range(0, 9) == 0);
      mem_valid_i   = ($urandom_range(0, 9) < 6);
      mem_rd_i      = 5'($urandom_range(0, 3));
      mem_reg_we_i  = ($urandom_range(0, 9) < 7);
      wb_valid_i    = ($urandom_range(0, 9) < 6);
      wb_rd_i       = 5'($urandom_range(0, 3));
      wb_reg_we_i   = ($urandom_range(0, 9) < 7);
      dmem_req_i    = (m_wait > 0) ? 1'b1 : ($urandom_range(0, 99) < 15);
      dmem_ack_i    = ($urandom_range(0, 9) < 3);
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
